// File: rtl/setpoint_tracker.sv
// rtl/setpoint_tracker.sv - clamped setpoint with tick-paced tracking of an actual value and RGB band status
// Optional hold-to-auto-repeat of the buttons: define SETPOINT_AUTO_REPEAT_EN.
module setpoint_tracker #(
   parameter int W        = 8,
   parameter int SP_MIN   = 0,
   parameter int SP_MAX   = 255,
   parameter int SP_INIT  = 25,
   parameter int ACT_INIT = 0,
   parameter int TICK_PER = 16777216,
   parameter int HYST     = 0,
   parameter int RPT_DLY  = 25000000,
   parameter int RPT_PER  = 5000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_i,
   input  logic         dn_i,
   output logic [W-1:0] setpoint,
   output logic [W-1:0] actual,
   output logic         tick_o,
   output logic [2:0]   rgb
);

   localparam int W1 = W + 1;
   localparam int TW = (TICK_PER > 1) ? $clog2(TICK_PER) : 1;

   logic up_q, dn_q, up_prev, dn_prev;
   logic up_press, dn_press;
   logic up_step, dn_step;

   // register the button levels once, and keep the previous sample for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_q    <= 1'b0;
         dn_q    <= 1'b0;
         up_prev <= 1'b0;
         dn_prev <= 1'b0;
      end else begin
         up_q    <= up_i;
         dn_q    <= dn_i;
         up_prev <= up_q;
         dn_prev <= dn_q;
      end
   end

   assign up_press = up_q & ~up_prev;
   assign dn_press = dn_q & ~dn_prev;

`ifdef SETPOINT_AUTO_REPEAT_EN
   localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
   localparam int RW   = $clog2(RMAX + 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

   // index 0 is the up button, index 1 the down button
   rpt_state_t      st  [2];
   logic [RW-1:0]   cnt [2];
   logic [1:0]      held, press, step;
   logic            both_held;

   assign held      = {dn_q, up_q};
   assign press     = {dn_press, up_press};
   assign both_held = up_q & dn_q;

   // per-direction hold/repeat FSM; the counter holds cycles spent in the current state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            st[i]  <= IDLE;
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (both_held || !held[i]) begin
               st[i]  <= IDLE;
               cnt[i] <= '0;
            end else begin
               case (st[i])
                  IDLE: begin
                     if (press[i]) begin
                        st[i]  <= HOLD;
                        cnt[i] <= RW'(1);
                     end
                  end
                  HOLD: begin
                     if (cnt[i] == RW'(RPT_DLY)) begin
                        st[i]  <= REPEAT;
                        cnt[i] <= RW'(1);
                     end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                     end
                  end
                  REPEAT: begin
                     if (cnt[i] == RW'(RPT_PER)) cnt[i] <= RW'(1);
                     else                        cnt[i] <= cnt[i] + 1'b1;
                  end
                  default: begin
                     st[i]  <= IDLE;
                     cnt[i] <= '0;
                  end
               endcase
            end
         end
      end
   end

   // a step is due on the initial press and whenever the hold or repeat interval completes
   always_comb begin
      step = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (!both_held && held[i]) begin
            case (st[i])
               IDLE:    step[i] = press[i];
               HOLD:    step[i] = (cnt[i] == RW'(RPT_DLY));
               REPEAT:  step[i] = (cnt[i] == RW'(RPT_PER));
               default: step[i] = 1'b0;
            endcase
         end
      end
   end

   assign up_step = step[0];
   assign dn_step = step[1];
`else
   // one step per press; a press on one button while the other is held still counts
   assign up_step = up_press;
   assign dn_step = dn_press;
`endif

   // saturating setpoint update; opposing steps in the same cycle cancel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         setpoint <= W'(SP_INIT);
      end else if (up_step && !dn_step) begin
         if (setpoint < W'(SP_MAX)) setpoint <= setpoint + 1'b1;
      end else if (dn_step && !up_step) begin
         if (setpoint > W'(SP_MIN)) setpoint <= setpoint - 1'b1;
      end
   end

   logic [TW-1:0] tcnt, tcnt_nxt;

   assign tcnt_nxt = (tcnt == TW'(TICK_PER - 1)) ? '0 : tcnt + 1'b1;

   // free-running tick counter; tick_o is registered so it is aligned with the terminal count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt   <= '0;
         tick_o <= 1'b0;
      end else begin
         tcnt   <= tcnt_nxt;
         tick_o <= (tcnt_nxt == TW'(TICK_PER - 1));
      end
   end

   // move actual one unit toward the setpoint on each tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         actual <= W'(ACT_INIT);
      end else if (tick_o) begin
         if (actual < setpoint)      actual <= actual + 1'b1;
         else if (actual > setpoint) actual <= actual - 1'b1;
      end
   end

   logic [W:0] act_x, sp_x, act_hi, sp_hi;
   logic       below, above;

   // band edges are computed one bit wider so setpoint + HYST cannot wrap
   assign act_x  = {1'b0, actual};
   assign sp_x   = {1'b0, setpoint};
   assign act_hi = act_x + W1'(HYST);
   assign sp_hi  = sp_x + W1'(HYST);
   assign below  = (act_hi < sp_x);
   assign above  = (act_x > sp_hi);

   // active-low status, exactly one LED lit once out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rgb <= 3'b111;
      else if (below) rgb <= 3'b110;
      else if (above) rgb <= 3'b011;
      else            rgb <= 3'b101;
   end

endmodule

// File: tb/tb_setpoint_tracker.sv
// tb/tb_setpoint_tracker.sv - directed self-checking bench for setpoint_tracker
module tb_setpoint_tracker;

   logic       clk = 1'b0;
   logic       rst_a = 1'b1, rst_b = 1'b1;
   logic       up_a = 1'b0, dn_a = 1'b0, up_b = 1'b0, dn_b = 1'b0;
   logic       up_c = 1'b0, dn_c = 1'b0;
   logic [7:0] sp_a, act_a, sp_b, act_b, sp_c, act_c;
   logic       tick_a, tick_b, tick_c;
   logic [2:0] rgb_a, rgb_b, rgb_c;

   int tests = 0;
   int fails = 0;

`ifdef SETPOINT_AUTO_REPEAT_EN
   localparam int EXP_HELD_DN = 4;
   localparam int EXP_RPT     = 10;
`else
   localparam int EXP_HELD_DN = 3;
   localparam int EXP_RPT     = 6;
`endif

   always #5 clk = ~clk;

   setpoint_tracker #(
      .W(8), .SP_MIN(0), .SP_MAX(30), .SP_INIT(25), .ACT_INIT(0),
      .TICK_PER(4), .HYST(0), .RPT_DLY(10), .RPT_PER(3)
   ) u_dut_a (
      .clk(clk), .rst(rst_a), .up_i(up_a), .dn_i(dn_a),
      .setpoint(sp_a), .actual(act_a), .tick_o(tick_a), .rgb(rgb_a)
   );

   setpoint_tracker #(
      .W(8), .SP_MIN(0), .SP_MAX(255), .SP_INIT(20), .ACT_INIT(23),
      .TICK_PER(16), .HYST(2), .RPT_DLY(10), .RPT_PER(3)
   ) u_dut_b (
      .clk(clk), .rst(rst_b), .up_i(up_b), .dn_i(dn_b),
      .setpoint(sp_b), .actual(act_b), .tick_o(tick_b), .rgb(rgb_b)
   );

   setpoint_tracker #(
      .W(8), .TICK_PER(1)
   ) u_dut_c (
      .clk(clk), .rst(rst_a), .up_i(up_c), .dn_i(dn_c),
      .setpoint(sp_c), .actual(act_c), .tick_o(tick_c), .rgb(rgb_c)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] get_act(input int sel);
      return (sel == 0) ? act_a : act_b;
   endfunction

   // pulse one button for a single cycle, n times, with idle cycles between
   task automatic press(input int sel, input bit is_up, input int n);
      for (int k = 0; k < n; k++) begin
         if (sel == 0) begin
            if (is_up) up_a = 1'b1; else dn_a = 1'b1;
         end else begin
            if (is_up) up_b = 1'b1; else dn_b = 1'b1;
         end
         @(negedge clk);
         up_a = 1'b0; dn_a = 1'b0; up_b = 1'b0; dn_b = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   task automatic wait_act(input int sel, input int val, input int budget, input string tag);
      int n = 0;
      while (get_act(sel) != 8'(val) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, get_act(sel), val);
   endtask

   initial begin
      int cyc;
      int ticks;

      repeat (3) @(negedge clk);
      check("rst_sp", sp_a, 25);
      check("rst_act", act_a, 0);
      check("rst_tick", tick_a, 0);
      check("rst_rgb", rgb_a, 3'b111);
      check("rst_tick1", tick_c, 0);

      // reset release: tick every 4 cycles, actual climbs one unit per tick
      rst_a = 1'b0;
      cyc = 0;
      ticks = 0;
      while (act_a != 8'd25 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (tick_a) ticks++;
         if (cyc <= 8) check("tick_pat", tick_a, (cyc % 4) == 3);
         if (cyc <= 3) check("tick_per1", tick_c, 1);
         if (cyc == 1) check("rgb_first", rgb_a, 3'b110);
         if (cyc == 4) check("act_first", act_a, 1);
      end
      check("reach_cyc", cyc, 100);
      check("reach_ticks", ticks, 25);
      check("reach_act", act_a, 25);
      check("rgb_at24", rgb_a, 3'b110);
      @(negedge clk);
      check("rgb_at25", rgb_a, 3'b101);
      repeat (12) @(negedge clk);
      check("act_hold", act_a, 25);
      check("rgb_hold", rgb_a, 3'b101);

      // upper clamp
      press(0, 1'b1, 4);
      check("sp_29", sp_a, 29);
      for (int k = 0; k < 3; k++) begin
         press(0, 1'b1, 1);
         check("sp_max", sp_a, 30);
      end

      // lower clamp
      press(0, 1'b0, 30);
      check("sp_0", sp_a, 0);
      press(0, 1'b0, 1);
      check("sp_min", sp_a, 0);
      press(0, 1'b1, 3);
      check("sp_3", sp_a, 3);

      // simultaneous presses cancel
      up_a = 1'b1; dn_a = 1'b1;
      @(negedge clk);
      up_a = 1'b0; dn_a = 1'b0;
      repeat (3) @(negedge clk);
      check("sp_both", sp_a, 3);

      // down pressed while up is held
      up_a = 1'b1;
      repeat (3) @(negedge clk);
      check("sp_held_up", sp_a, 4);
      dn_a = 1'b1;
      @(negedge clk);
      dn_a = 1'b0;
      repeat (2) @(negedge clk);
      check("sp_held_dn", sp_a, EXP_HELD_DN);
      up_a = 1'b0;
      repeat (2) @(negedge clk);

      // long hold from 5
      press(0, 1'b0, 10);
      press(0, 1'b1, 5);
      check("sp_5", sp_a, 5);
      up_a = 1'b1;
      repeat (20) @(negedge clk);
      up_a = 1'b0;
      repeat (3) @(negedge clk);
      check("sp_rpt", sp_a, EXP_RPT);
      repeat (10) @(negedge clk);
      check("sp_rpt_rel", sp_a, EXP_RPT);

      // reset mid-tick with a button held
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      wait_act(0, 12, 100, "act_12");
      up_a = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_a = 1'b1;
      #1;
      check("arst_sp", sp_a, 25);
      check("arst_act", act_a, 0);
      check("arst_tick", tick_a, 0);
      check("arst_rgb", rgb_a, 3'b111);
      check("arst_tick1", tick_c, 0);
      up_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b0;
      repeat (6) @(negedge clk);
      check("post_sp", sp_a, 25);
      check("post_act", act_a, 1);
      check("post_rgb", rgb_a, 3'b110);

      // hysteresis band: setpoint 20, HYST 2
      rst_b = 1'b0;
      @(negedge clk);
      check("hy_23", rgb_b, 3'b011);
      wait_act(1, 22, 100, "hy_act22");
      @(negedge clk);
      check("hy_22", rgb_b, 3'b101);
      wait_act(1, 20, 100, "hy_act20");
      press(1, 1'b0, 5);
      check("hy_sp15", sp_b, 15);
      wait_act(1, 15, 200, "hy_act15");
      press(1, 1'b1, 5);
      check("hy_sp20", sp_b, 20);
      wait_act(1, 17, 100, "hy_act17");
      @(negedge clk);
      check("hy_17", rgb_b, 3'b110);
      wait_act(1, 18, 100, "hy_act18");
      @(negedge clk);
      check("hy_18", rgb_b, 3'b101);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
